// File: rtl/axi_pkg.sv
// Shared AXI4-Lite definitions for the data-memory subordinate: response codes
// and the write/read channel state encodings.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_WAIT = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } r_state_e;

endpackage

// File: rtl/dmem_bram.sv
// DEPTH x 32 data RAM: one synchronous byte-enabled write port and one
// synchronous read port; a same-edge read of the written word sees old data.
module dmem_bram #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       wbe,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  // Non-blocking update of both ports gives read-before-write on a shared word.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axi_dmem_slave.sv
// AXI4-Lite subordinate wrapping the core data memory; one outstanding write and
// one outstanding read. Define DMEM_DECERR_EN to answer out-of-range addresses with DECERR.
module axi_dmem_slave
  import axi_pkg::*;
#(
  parameter int AXI_AWIDTH = 32,
  parameter int AXI_DWIDTH = 32,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    CLK,
  input  logic                    NRST,
  input  logic [AXI_AWIDTH-1:0]   AXI_AWADDR,
  input  logic                    AXI_AWVALID,
  output logic                    AXI_AWREADY,
  input  logic [AXI_DWIDTH-1:0]   AXI_WDATA,
  input  logic [AXI_DWIDTH/8-1:0] AXI_WSTRB,
  input  logic                    AXI_WVALID,
  output logic                    AXI_WREADY,
  output logic [1:0]              AXI_BRESP,
  output logic                    AXI_BVALID,
  input  logic                    AXI_BREADY,
  input  logic [AXI_AWIDTH-1:0]   AXI_ARADDR,
  input  logic                    AXI_ARVALID,
  output logic                    AXI_ARREADY,
  output logic [AXI_DWIDTH-1:0]   AXI_RDATA,
  output logic [1:0]              AXI_RRESP,
  output logic                    AXI_RVALID,
  input  logic                    AXI_RREADY,
  output logic [1:0]              dbg_w_state,
  output logic                    dbg_r_state
);

  // Handshakes: a transfer happens on the rising edge where VALID and READY are
  // both high; VALID never waits on READY, and READY/VALID come only from flops.
  localparam int IDX_W = $clog2(MEM_DEPTH);

  w_state_e                w_state_q, w_state_d;
  logic                    aw_have_q, aw_have_d;
  logic                    w_have_q, w_have_d;
  logic [AXI_AWIDTH-1:0]   awaddr_q, awaddr_d;
  logic [AXI_DWIDTH-1:0]   wdata_q, wdata_d;
  logic [AXI_DWIDTH/8-1:0] wstrb_q, wstrb_d;
  logic [1:0]              bresp_q, bresp_d;
  r_state_e                r_state_q, r_state_d;
  logic [1:0]              rresp_q, rresp_d;

  logic                    aw_hs, w_hs, ar_hs;
  logic [AXI_AWIDTH-1:0]   waddr_eff;
  logic [AXI_DWIDTH-1:0]   wdata_eff;
  logic [AXI_DWIDTH/8-1:0] wstrb_eff;
  logic                    w_decerr, r_decerr;
  logic                    ram_we, ram_re;
  logic [31:0]             ram_rdata;

  assign AXI_AWREADY = (w_state_q == W_IDLE) || ((w_state_q == W_WAIT) && !aw_have_q);
  assign AXI_WREADY  = (w_state_q == W_IDLE) || ((w_state_q == W_WAIT) && !w_have_q);
  assign AXI_BVALID  = (w_state_q == W_RESP);
  assign AXI_BRESP   = bresp_q;
  assign AXI_ARREADY = (r_state_q == R_IDLE);
  assign AXI_RVALID  = (r_state_q == R_RESP);
  assign AXI_RRESP   = rresp_q;
  assign AXI_RDATA   = (AXI_RVALID && (rresp_q == RESP_OKAY)) ? ram_rdata : '0;
  assign dbg_w_state = w_state_q;
  assign dbg_r_state = r_state_q;

  assign aw_hs = AXI_AWVALID && AXI_AWREADY;
  assign w_hs  = AXI_WVALID && AXI_WREADY;
  assign ar_hs = AXI_ARVALID && AXI_ARREADY;

  // The second handshake may arrive on the completing edge, so bypass the holding regs.
  assign waddr_eff = aw_hs ? AXI_AWADDR : awaddr_q;
  assign wdata_eff = w_hs ? AXI_WDATA : wdata_q;
  assign wstrb_eff = w_hs ? AXI_WSTRB : wstrb_q;

`ifdef DMEM_DECERR_EN
  assign w_decerr = (waddr_eff >> (IDX_W + 2)) != '0;
  assign r_decerr = (AXI_ARADDR >> (IDX_W + 2)) != '0;
`else
  assign w_decerr = 1'b0;
  assign r_decerr = 1'b0;
`endif

  always_comb begin
    w_state_d = w_state_q;
    aw_have_d = aw_have_q;
    w_have_d  = w_have_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    ram_we    = 1'b0;
    if (aw_hs) begin
      aw_have_d = 1'b1;
      awaddr_d  = AXI_AWADDR;
    end
    if (w_hs) begin
      w_have_d = 1'b1;
      wdata_d  = AXI_WDATA;
      wstrb_d  = AXI_WSTRB;
    end
    case (w_state_q)
      W_IDLE, W_WAIT: begin
        if (aw_have_d && w_have_d) begin
          ram_we    = !w_decerr;
          bresp_d   = w_decerr ? RESP_DECERR : RESP_OKAY;
          aw_have_d = 1'b0;
          w_have_d  = 1'b0;
          w_state_d = W_RESP;
        end else if (aw_have_d || w_have_d) begin
          w_state_d = W_WAIT;
        end
      end
      W_RESP: if (AXI_BREADY) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    rresp_d   = rresp_q;
    ram_re    = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          ram_re    = 1'b1;
          rresp_d   = r_decerr ? RESP_DECERR : RESP_OKAY;
          r_state_d = R_RESP;
        end
      end
      R_RESP: if (AXI_RREADY) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      w_state_q <= W_IDLE;
      aw_have_q <= 1'b0;
      w_have_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
      r_state_q <= R_IDLE;
      rresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      aw_have_q <= aw_have_d;
      w_have_q  <= w_have_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      rresp_q   <= rresp_d;
    end
  end

  dmem_bram #(
    .DEPTH (MEM_DEPTH)
  ) u_bram (
    .clk   (CLK),
    .we    (ram_we),
    .wbe   (wstrb_eff),
    .waddr (IDX_W'(waddr_eff >> 2)),
    .wdata (wdata_eff),
    .re    (ram_re),
    .raddr (IDX_W'(AXI_ARADDR >> 2)),
    .rdata (ram_rdata)
  );

endmodule
